// File: rtl/fetch_block_pkg.sv
// Shared fetch/decode types and constants for the instruction fetch stage.
package fetch_block_pkg;
  localparam int WORD      = 32;
  localparam int HALF_WORD = 16;

  localparam logic [WORD-1:0] FETCH_RESET_PC = 32'h0000_0000;

  typedef logic [HALF_WORD-1:0] instruction;
  typedef logic                 stall_pipeline_sig;
  typedef logic                 flush_pipeline_sig;

  typedef enum logic [1:0] {RESET_HOLD, RUN, DRAIN} fetch_state_e;

  typedef struct packed {
    instruction      instr;
    logic [WORD-1:0] pc;
  } fetch_entry_t;

  function automatic logic [WORD-1:0] next_half(input logic [WORD-1:0] a);
    return a + WORD'(2);
  endfunction
endpackage

// File: rtl/fetch_prefetch_fifo.sv
// Synchronous prefetch FIFO of {instruction, pc}; clear drops all entries.
module fetch_prefetch_fifo
  import fetch_block_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     clear,
  output fetch_entry_t             head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
endmodule

// File: rtl/fetch_block.sv
// Instruction fetch stage: PC, credit-limited imem requests, prefetch FIFO, output register.
// Define FETCH_PERF_CNT_EN to add stall_cycles_o / flush_count_o counters.
module fetch_block
  import fetch_block_pkg::*;
#(
  parameter logic [WORD-1:0] RESET_PC   = FETCH_RESET_PC,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  stall_pipeline_sig stall_pipeline_i,
  input  flush_pipeline_sig flush_pipeline_i,
  input  logic [WORD-1:0]   branch_target_i,
  output logic              imem_req_o,
  output logic [WORD-1:0]   imem_addr_o,
  input  logic              imem_ack_i,
  input  logic              imem_rvalid_i,
  input  instruction        imem_rdata_i,
  output instruction        instruction_o,
  output logic [WORD-1:0]   program_counter_o,
  output logic              is_valid_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles_o,
  output logic [31:0]       flush_count_o
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e    state, state_nxt;
  logic [WORD-1:0] fetch_pc, rsp_pc, redirect_pc;
  logic [CW-1:0]   outstanding, outstanding_nxt, discard_cnt, discard_nxt, fifo_count;
  logic [CW:0]     credit;
  logic            issue, accept, load_en, bypass, push, pop, fifo_empty;
  fetch_entry_t    head, rsp_entry;

  // Credits cover both buffered and in-flight responses, so the FIFO cannot overflow.
  assign credit      = {1'b0, fifo_count} + {1'b0, outstanding};
  assign imem_req_o  = (state != RESET_HOLD) && (credit < (CW+1)'(FIFO_DEPTH)) && !flush_pipeline_i;
  assign imem_addr_o = fetch_pc;
  assign issue       = imem_req_o && imem_ack_i;
  assign redirect_pc = branch_target_i & ~WORD'(1);

  assign accept    = imem_rvalid_i && !flush_pipeline_i && (discard_cnt == '0);
  assign load_en   = !is_valid_o || !stall_pipeline_i;
  assign bypass    = accept && load_en && fifo_empty;
  assign push      = accept && !bypass;
  assign pop       = load_en && !fifo_empty && !flush_pipeline_i;
  assign rsp_entry = '{instr: imem_rdata_i, pc: rsp_pc};

  assign outstanding_nxt = outstanding + CW'(issue) - CW'(imem_rvalid_i);

  always_comb begin
    discard_nxt = discard_cnt;
    if (flush_pipeline_i)
      discard_nxt = outstanding_nxt;
    else if (imem_rvalid_i && discard_cnt != '0)
      discard_nxt = discard_cnt - CW'(1);

    state_nxt = state;
    case (state)
      RESET_HOLD: state_nxt = RUN;
      DRAIN:      if (discard_nxt == '0) state_nxt = RUN;
      default:    ;
    endcase
    if (flush_pipeline_i)
      state_nxt = (discard_nxt != '0) ? DRAIN : RUN;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= RESET_HOLD;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard_cnt <= '0;
    end else begin
      state       <= state_nxt;
      outstanding <= outstanding_nxt;
      discard_cnt <= discard_nxt;
      // Pre-flush responses are all discarded, so the next kept one is the target.
      if (flush_pipeline_i) begin
        fetch_pc <= redirect_pc;
        rsp_pc   <= redirect_pc;
      end else begin
        if (issue)  fetch_pc <= next_half(fetch_pc);
        if (accept) rsp_pc   <= next_half(rsp_pc);
      end
    end
  end

  fetch_prefetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk_i),
    .rst       (reset_i),
    .push      (push),
    .push_data (rsp_entry),
    .pop       (pop),
    .clear     (flush_pipeline_i),
    .head      (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      instruction_o     <= '0;
      program_counter_o <= RESET_PC;
      is_valid_o        <= 1'b0;
    end else if (flush_pipeline_i) begin
      is_valid_o <= 1'b0;
    end else if (load_en) begin
      if (!fifo_empty) begin
        instruction_o     <= head.instr;
        program_counter_o <= head.pc;
        is_valid_o        <= 1'b1;
      end else if (bypass) begin
        instruction_o     <= rsp_entry.instr;
        program_counter_o <= rsp_entry.pc;
        is_valid_o        <= 1'b1;
      end else begin
        is_valid_o <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stall_cycles_o <= '0;
      flush_count_o  <= '0;
    end else begin
      if (is_valid_o && stall_pipeline_i) stall_cycles_o <= stall_cycles_o + 32'd1;
      if (flush_pipeline_i)               flush_count_o  <= flush_count_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_block.sv
// Randomized bench for fetch_block against a queue-based model of memory and instruction stream.
module tb_fetch_block;
  logic        clk, rst, stall, flush, ack, rvalid, req, valid;
  logic [31:0] target, addr, pc;
  logic [15:0] rdata, instr;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  fetch_block #(.RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
    .clk_i             (clk),
    .reset_i           (rst),
    .stall_pipeline_i  (stall),
    .flush_pipeline_i  (flush),
    .branch_target_i   (target),
    .imem_req_o        (req),
    .imem_addr_o       (addr),
    .imem_ack_i        (ack),
    .imem_rvalid_i     (rvalid),
    .imem_rdata_i      (rdata),
    .instruction_o     (instr),
    .program_counter_o (pc),
    .is_valid_o        (valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cycles_o    (stall_cycles),
    .flush_count_o     (flush_count)
`endif
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  typedef struct packed { logic [31:0] a; logic [15:0] d; } ent_t;

  ent_t        memq[$];  // requests the memory has accepted, in order
  ent_t        fq[$];    // responses kept but not yet presented
  bit          m_hold, m_vld;
  logic [31:0] m_pc, m_opc;
  logic [15:0] m_oin;
  int          m_stale;
  int          errors = 0;
  int          checks = 0;

  function automatic logic [15:0] dat(input logic [31:0] a);
    return a[15:0] ^ 16'hC0DE;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge: check registered outputs, drive this cycle, check request, advance model.
  task automatic step(input bit st, input bit fl, input logic [31:0] tg, input bit ak, input bit rv);
    ent_t e, n;
    bit   got, mreq;
    chk("valid", valid, m_vld);
    if (m_vld) begin
      chk("pc", pc, m_opc);
      chk("instr", instr, m_oin);
    end
    stall = st; flush = fl; target = tg; ack = ak;
    rvalid = rv && (memq.size() > 0);
    rdata  = rvalid ? memq[0].d : 16'h0;
    #1;
    mreq = !m_hold && (fq.size() + memq.size() < 4) && !fl;
    chk("req", req, mreq);
    if (mreq) chk("addr", addr, m_pc);
    got = 0;
    e   = '0;
    if (rvalid) begin
      e = memq.pop_front();
      if (!fl && m_stale == 0) got = 1;
      else if (m_stale > 0) m_stale--;
    end
    if (mreq && ak) begin
      n.a = m_pc; n.d = dat(m_pc);
      memq.push_back(n);
      m_pc += 2;
    end
    m_hold = 0;
    if (fl) begin
      fq.delete();
      m_vld   = 0;
      m_stale = memq.size();
      m_pc    = tg & 32'hFFFF_FFFE;
    end else if (!m_vld || !st) begin
      if (fq.size() > 0) begin
        n = fq.pop_front();
        m_opc = n.a; m_oin = n.d; m_vld = 1;
        if (got) fq.push_back(e);
      end else if (got) begin
        m_opc = e.a; m_oin = e.d; m_vld = 1;
      end else begin
        m_vld = 0;
      end
    end else if (got) begin
      fq.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; stall = 0; flush = 0; ack = 0; rvalid = 0; rdata = 0; target = 0;
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 0);
    chk("rst_req", req, 0);
    chk("rst_addr", addr, 32'h0);
    memq.delete(); fq.delete();
    m_hold = 1; m_pc = 0; m_stale = 0; m_vld = 0; m_opc = 0; m_oin = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic run_until_valid(input int budget);
    int n = 0;
    while (!valid && n < budget) begin
      step(0, 0, 0, 1, 1);
      n++;
    end
    chk("wait_valid", valid, 1);
  endtask

  initial begin
    rst = 1; stall = 0; flush = 0; ack = 0; rvalid = 0; rdata = 0; target = 0;
    @(negedge clk);

    // Streaming after reset: issue from the second cycle, bypass gives 1-cycle response latency.
    do_reset();
    step(0, 0, 0, 1, 1); chk("d1_addr0", addr, 32'h0);
    step(0, 0, 0, 1, 1); chk("d1_addr2", addr, 32'h2);
    step(0, 0, 0, 1, 1); chk("d1_addr4", addr, 32'h4);
    chk("d1_valid", valid, 1); chk("d1_pc0", pc, 32'h0); chk("d1_in0", instr, 32'hC0DE);
    step(0, 0, 0, 1, 1); chk("d1_addr6", addr, 32'h6);
    chk("d1_pc2", pc, 32'h2); chk("d1_in2", instr, 32'hC0DC);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1);

    // Memory not acking: request held stable.
    do_reset();
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0);
      chk("d2_req", req, 1); chk("d2_addr", addr, 32'h0); chk("d2_valid", valid, 0);
    end

    // Stall while the FIFO fills: outputs hold, credits run out.
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 1, 1);
      chk("d3_hold_pc", pc, 32'h0); chk("d3_hold_v", valid, 1);
    end
    chk("d3_req_drop", req, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 1);

    // Flush with 3 outstanding: stale responses dropped, target bit 0 ignored.
    do_reset();
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    step(0, 1, 32'h101, 1, 0);
    chk("d4_valid_off", valid, 0);
    run_until_valid(30);
    chk("d4_pc", pc, 32'h100); chk("d4_in", instr, 32'hC1DE);

    // Flush and stall together with a valid output.
    step(1, 1, 32'h200, 1, 1);
    chk("d5_valid_off", valid, 0);
    run_until_valid(30);
    chk("d5_pc", pc, 32'h200);

    // Reset mid-burst with 2 outstanding.
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    do_reset();
    step(0, 0, 0, 1, 1);
    chk("d6_addr", addr, 32'h0);
    run_until_valid(30);
    chk("d6_pc", pc, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) < 3) do_reset();
      step($urandom_range(0, 9) < 3, $urandom_range(0, 99) < 5, $urandom,
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
